// File: rtl/panel_pkg.sv
// panel_pkg: shared panel mode one-hot codes, command op codes, button indices and mode stepping
package panel_pkg;
  localparam logic [2:0] COND_CNT_EN = 3'b100;
  localparam logic [2:0] COND_LRU_WR = 3'b010;
  localparam logic [2:0] COND_LRU_RD = 3'b001;
  localparam logic [1:0] OP_CNT_TOGGLE = 2'b00;
  localparam logic [1:0] OP_LRU_WR = 2'b01;
  localparam logic [1:0] OP_LRU_RD = 2'b10;
  localparam logic [1:0] OP_CLR = 2'b11;
  localparam int BTN_C = 0;
  localparam int BTN_U = 1;
  localparam int BTN_L = 2;
  localparam int BTN_R = 3;
  typedef enum logic [2:0] {
    CNT_EN = COND_CNT_EN,
    LRU_WR = COND_LRU_WR,
    LRU_RD = COND_LRU_RD
  } mode_e;
  function automatic mode_e mode_step(input mode_e m, input logic fwd);
    return fwd ? (m == CNT_EN ? LRU_WR : m == LRU_WR ? LRU_RD : CNT_EN)
               : (m == CNT_EN ? LRU_RD : m == LRU_RD ? LRU_WR : CNT_EN);
  endfunction
endpackage

// File: rtl/panel_input_btn_debounce.sv
// btn_debounce: two-flop synchronizer, stability counter, stable level and registered press pulse
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 100000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic press_o
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  logic [1:0] sync_q, sync_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic stable_q, stable_d, prev_q, press_q, press_d;
  always_comb begin
    sync_d = {sync_q[0], btn_i};
    stable_d = (sync_q[1] != stable_q && cnt_q == CW'(DEBOUNCE_CYCLES - 1)) ? sync_q[1] : stable_q;
    cnt_d = (sync_q[1] == stable_q || stable_d != stable_q) ? '0 : cnt_q + 1'b1;
    press_d = stable_q & ~prev_q;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '0;
      cnt_q <= '0;
      stable_q <= 1'b0;
      prev_q <= 1'b0;
      press_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      cnt_q <= cnt_d;
      stable_q <= stable_d;
      prev_q <= stable_q;
      press_q <= press_d;
    end
  end
  assign press_o = press_q;
endmodule

// File: rtl/panel_input.sv
// panel_input: debounced front-panel buttons drive the one-hot mode and valid/ready commands; define PANEL_DROP_CNT_EN to add drop_cnt_o
module panel_input
  import panel_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter int SW_W = 16
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [3:0]      btn_i,
  input  logic [SW_W-1:0] sw_i,
  output logic [2:0]      state_o,
  output logic [SW_W-1:0] sw_o,
  output logic            cmd_valid_o,
  input  logic            cmd_ready_i,
  output logic [1:0]      cmd_op_o,
  output logic [SW_W-1:0] cmd_data_o,
  output logic            busy_o
`ifdef PANEL_DROP_CNT_EN
  ,
  output logic [7:0]      drop_cnt_o
`endif
);
  logic [3:0] press;
  logic [SW_W-1:0] sw1_q, sw_q, sw1_d, sw_d;
  mode_e mode_q, mode_d;
  logic valid_q, valid_d, issue, step;
  logic [1:0] op_q, op_d;
  logic [SW_W-1:0] data_q, data_d;
  for (genvar i = 0; i < 4; i++) begin : g_btn
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .btn_i  (btn_i[i]),
      .press_o(press[i])
    );
  end
  always_comb begin
    sw1_d = sw_i;
    sw_d = sw1_q;
    issue = ~valid_q & (press[BTN_U] | press[BTN_C]);
    step = ~valid_q & ~issue & (press[BTN_R] ^ press[BTN_L]);
    valid_d = issue | (valid_q & ~cmd_ready_i);
    op_d = !issue ? op_q : press[BTN_U] ? OP_CLR : mode_q == CNT_EN ? OP_CNT_TOGGLE :
           mode_q == LRU_WR ? OP_LRU_WR : OP_LRU_RD;
    data_d = !issue ? data_q : (press[BTN_U] | (mode_q == CNT_EN)) ? '0 : sw_q;
    mode_d = step ? mode_step(mode_q, press[BTN_R]) : mode_q;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sw1_q <= '0;
      sw_q <= '0;
      mode_q <= CNT_EN;
      valid_q <= 1'b0;
      op_q <= '0;
      data_q <= '0;
    end else begin
      sw1_q <= sw1_d;
      sw_q <= sw_d;
      mode_q <= mode_d;
      valid_q <= valid_d;
      op_q <= op_d;
      data_q <= data_d;
    end
  end
  assign state_o = mode_q;
  assign sw_o = sw_q;
  assign cmd_valid_o = valid_q;
  assign busy_o = valid_q;
  assign cmd_op_o = op_q;
  assign cmd_data_o = data_q;
`ifdef PANEL_DROP_CNT_EN
  logic [7:0] drop_q, drop_d;
  logic drop;
  always_comb begin
    drop = valid_q ? (press[BTN_U] | press[BTN_C]) : (press[BTN_U] & press[BTN_C]);
    drop_d = (drop && drop_q != 8'hFF) ? drop_q + 8'd1 : drop_q;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) drop_q <= '0;
    else drop_q <= drop_d;
  end
  assign drop_cnt_o = drop_q;
`endif
endmodule

// File: tb/tb_panel_input.sv
// tb_panel_input: directed and randomized checks of panel_input against a behavioural model
module tb_panel_input;
  localparam int D = 4;
  localparam int W = 16;
  logic clk_i = 1'b0;
  logic rst_i, cmd_ready_i, cmd_valid_o, busy_o;
  logic [3:0] btn_i;
  logic [W-1:0] sw_i, sw_o, cmd_data_o;
  logic [2:0] state_o;
  logic [1:0] cmd_op_o;
`ifdef PANEL_DROP_CNT_EN
  logic [7:0] drop_cnt_o;
`endif
  int vectors = 0, miscompares = 0;
  logic [W-1:0] sw_v = '0;
  logic rdy_v = 1'b0;
  logic [3:0] m_s1, m_s2, m_stab, m_rise, m_press;
  int m_run[4];
  logic [W-1:0] m_sw1, m_sw2, m_data;
  logic m_valid;
  logic [1:0] m_op;
  int m_idx, m_drop;
  panel_input #(.DEBOUNCE_CYCLES(D), .SW_W(W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .btn_i(btn_i), .sw_i(sw_i), .state_o(state_o), .sw_o(sw_o),
    .cmd_valid_o(cmd_valid_o), .cmd_ready_i(cmd_ready_i), .cmd_op_o(cmd_op_o),
    .cmd_data_o(cmd_data_o), .busy_o(busy_o)
`ifdef PANEL_DROP_CNT_EN
    , .drop_cnt_o(drop_cnt_o)
`endif
  );
  always #5 clk_i = ~clk_i;
  task automatic step(input logic [3:0] b, input logic [W-1:0] s, input logic rdy, input logic r);
    logic pc, pu, pl, pr, iss;
    btn_i = b; sw_i = s; cmd_ready_i = rdy; rst_i = r;
    @(posedge clk_i);
    if (r) begin
      m_s1 = '0; m_s2 = '0; m_stab = '0; m_rise = '0; m_press = '0;
      for (int i = 0; i < 4; i++) m_run[i] = 0;
      m_sw1 = '0; m_sw2 = '0; m_data = '0; m_valid = 1'b0; m_op = '0; m_idx = 0; m_drop = 0;
    end else begin
      pc = m_press[0]; pu = m_press[1]; pl = m_press[2]; pr = m_press[3];
      iss = !m_valid && (pu || pc);
      if ((m_valid && (pu || pc)) || (!m_valid && pu && pc)) m_drop = (m_drop < 255) ? m_drop + 1 : 255;
      if (!m_valid && !iss && (pl ^ pr)) m_idx = pr ? (m_idx + 1) % 3 : (m_idx + 2) % 3;
      if (iss) begin
        m_op = pu ? 2'd3 : 2'(m_idx);
        m_data = (pu || m_idx == 0) ? '0 : m_sw2;
      end
      m_valid = iss || (m_valid && !rdy);
      m_press = m_rise;
      m_rise = '0;
      for (int i = 0; i < 4; i++) begin
        if (m_s2[i] !== m_stab[i]) begin
          m_run[i]++;
          if (m_run[i] == D) begin
            m_stab[i] = m_s2[i];
            m_run[i] = 0;
            m_rise[i] = m_s2[i];
          end
        end else m_run[i] = 0;
      end
      m_s2 = m_s1; m_s1 = b; m_sw2 = m_sw1; m_sw1 = s;
    end
    #1;
  endtask
  task automatic pulse(input logic [3:0] mask, input int hi, input int lo);
    for (int i = 0; i < hi; i++) step(mask, sw_v, rdy_v, 1'b0);
    for (int i = 0; i < lo; i++) step(4'b0000, sw_v, rdy_v, 1'b0);
  endtask
  task automatic test_reset;
    step(4'b1111, 16'hFFFF, 1'b1, 1'b1);
    step(4'b0000, 16'h0000, 1'b0, 1'b1);
    vectors++; if (state_o !== 3'b100) begin miscompares++; $display("FAIL reset_state got=%b exp=100", state_o); end
    vectors++; if (sw_o !== 16'h0) begin miscompares++; $display("FAIL reset_sw got=%h exp=0000", sw_o); end
    vectors++; if (cmd_valid_o !== 1'b0) begin miscompares++; $display("FAIL reset_valid got=%b exp=0", cmd_valid_o); end
    vectors++; if (busy_o !== 1'b0) begin miscompares++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
    vectors++; if (cmd_op_o !== 2'b00) begin miscompares++; $display("FAIL reset_op got=%b exp=00", cmd_op_o); end
    vectors++; if (cmd_data_o !== 16'h0) begin miscompares++; $display("FAIL reset_data got=%h exp=0000", cmd_data_o); end
`ifdef PANEL_DROP_CNT_EN
    vectors++; if (drop_cnt_o !== 8'd0) begin miscompares++; $display("FAIL reset_drop got=%0d exp=0", drop_cnt_o); end
`endif
  endtask
  task automatic test_cnt_toggle;
    for (int n = 1; n <= 8; n++) begin
      step(4'b0001, '0, 1'b0, 1'b0);
      vectors++; if (cmd_valid_o !== (n == 8)) begin miscompares++; $display("FAIL latency cyc=%0d got=%b exp=%b", n, cmd_valid_o, n == 8); end
    end
    for (int n = 0; n < 3; n++) step(4'b0001, '0, 1'b0, 1'b0);
    vectors++; if (cmd_valid_o !== 1'b1 || busy_o !== 1'b1) begin miscompares++; $display("FAIL toggle_hold got=%b/%b exp=1/1", cmd_valid_o, busy_o); end
    vectors++; if (cmd_op_o !== 2'b00 || cmd_data_o !== 16'h0) begin miscompares++; $display("FAIL toggle_cmd got=%b/%h exp=00/0000", cmd_op_o, cmd_data_o); end
    step(4'b0001, '0, 1'b1, 1'b0);
    vectors++; if (cmd_valid_o !== 1'b0) begin miscompares++; $display("FAIL toggle_accept got=%b exp=0", cmd_valid_o); end
    for (int n = 0; n < 12; n++) step(4'b0000, '0, 1'b0, 1'b0);
    vectors++; if (cmd_valid_o !== 1'b0 || state_o !== 3'b100) begin miscompares++; $display("FAIL toggle_idle got=%b/%b exp=0/100", cmd_valid_o, state_o); end
  endtask
  task automatic test_mode;
    logic [2:0] exp[3];
    exp[0] = 3'b010; exp[1] = 3'b001; exp[2] = 3'b100;
    for (int k = 0; k < 3; k++) begin
      pulse(4'b1000, 6, 10);
      vectors++; if (state_o !== exp[k]) begin miscompares++; $display("FAIL mode_btnr%0d got=%b exp=%b", k, state_o, exp[k]); end
    end
    pulse(4'b0100, 6, 10);
    vectors++; if (state_o !== 3'b001) begin miscompares++; $display("FAIL mode_btnl got=%b exp=001", state_o); end
    vectors++; if (cmd_valid_o !== 1'b0) begin miscompares++; $display("FAIL mode_nocmd got=%b exp=0", cmd_valid_o); end
  endtask
  task automatic test_lru_wr;
    pulse(4'b0100, 6, 10);
    vectors++; if (state_o !== 3'b010) begin miscompares++; $display("FAIL wr_mode got=%b exp=010", state_o); end
    sw_v = 16'hA5C3;
    pulse(4'b0001, 6, 4);
    vectors++; if (cmd_valid_o !== 1'b1 || cmd_op_o !== 2'b01 || cmd_data_o !== 16'hA5C3) begin
      miscompares++; $display("FAIL wr_issue got=%b/%b/%h exp=1/01/a5c3", cmd_valid_o, cmd_op_o, cmd_data_o); end
    sw_v = 16'h0000;
    pulse(4'b0000, 0, 6);
    vectors++; if (cmd_valid_o !== 1'b1 || cmd_op_o !== 2'b01 || cmd_data_o !== 16'hA5C3) begin
      miscompares++; $display("FAIL wr_hold got=%b/%b/%h exp=1/01/a5c3", cmd_valid_o, cmd_op_o, cmd_data_o); end
    vectors++; if (sw_o !== 16'h0000) begin miscompares++; $display("FAIL wr_sw got=%h exp=0000", sw_o); end
    step(4'b0000, sw_v, 1'b1, 1'b0);
    vectors++; if (cmd_valid_o !== 1'b0) begin miscompares++; $display("FAIL wr_accept got=%b exp=0", cmd_valid_o); end
  endtask
  task automatic test_bounce;
    for (int k = 0; k < 4; k++) begin
      for (int n = 0; n < 4; n++) begin
        step((n < 3) ? 4'b0001 : 4'b0000, sw_v, 1'b0, 1'b0);
        vectors++; if (cmd_valid_o !== 1'b0 || state_o !== 3'b010) begin
          miscompares++; $display("FAIL bounce k=%0d n=%0d got=%b/%b exp=0/010", k, n, cmd_valid_o, state_o); end
      end
    end
    for (int n = 0; n < 15; n++) begin
      step(4'b0000, sw_v, 1'b0, 1'b0);
      vectors++; if (cmd_valid_o !== 1'b0 || state_o !== 3'b010) begin
        miscompares++; $display("FAIL bounce_tail n=%0d got=%b/%b exp=0/010", n, cmd_valid_o, state_o); end
    end
  endtask
  task automatic test_clr_drop;
    pulse(4'b1000, 6, 10);
    vectors++; if (state_o !== 3'b001) begin miscompares++; $display("FAIL clr_mode got=%b exp=001", state_o); end
    sw_v = 16'h5A5A;
    pulse(4'b0011, 6, 6);
    vectors++; if (cmd_valid_o !== 1'b1 || cmd_op_o !== 2'b11 || cmd_data_o !== 16'h0) begin
      miscompares++; $display("FAIL clr_issue got=%b/%b/%h exp=1/11/0000", cmd_valid_o, cmd_op_o, cmd_data_o); end
`ifdef PANEL_DROP_CNT_EN
    vectors++; if (drop_cnt_o !== 8'd1) begin miscompares++; $display("FAIL clr_drop1 got=%0d exp=1", drop_cnt_o); end
`endif
    pulse(4'b0001, 6, 8);
    vectors++; if (cmd_valid_o !== 1'b1 || cmd_op_o !== 2'b11) begin
      miscompares++; $display("FAIL clr_ignore got=%b/%b exp=1/11", cmd_valid_o, cmd_op_o); end
`ifdef PANEL_DROP_CNT_EN
    vectors++; if (drop_cnt_o !== 8'd2) begin miscompares++; $display("FAIL clr_drop2 got=%0d exp=2", drop_cnt_o); end
`endif
    step(4'b0000, sw_v, 1'b1, 1'b0);
    step(4'b0000, sw_v, 1'b0, 1'b0);
    vectors++; if (cmd_valid_o !== 1'b0) begin miscompares++; $display("FAIL clr_accept got=%b exp=0", cmd_valid_o); end
  endtask
  task automatic test_reset_pending;
    sw_v = 16'h1234;
    pulse(4'b0001, 6, 4);
    vectors++; if (cmd_valid_o !== 1'b1 || cmd_op_o !== 2'b10 || cmd_data_o !== 16'h1234 || state_o !== 3'b001) begin
      miscompares++; $display("FAIL rd_issue got=%b/%b/%h/%b exp=1/10/1234/001", cmd_valid_o, cmd_op_o, cmd_data_o, state_o); end
    step(4'b0000, sw_v, 1'b0, 1'b1);
    vectors++; if (cmd_valid_o !== 1'b0 || busy_o !== 1'b0) begin miscompares++; $display("FAIL rst_abort got=%b/%b exp=0/0", cmd_valid_o, busy_o); end
    vectors++; if (state_o !== 3'b100) begin miscompares++; $display("FAIL rst_state got=%b exp=100", state_o); end
    vectors++; if (sw_o !== 16'h0) begin miscompares++; $display("FAIL rst_sw got=%h exp=0000", sw_o); end
    step(4'b0000, sw_v, 1'b0, 1'b0);
  endtask
  task automatic test_random;
    logic [3:0] b;
    logic [W-1:0] s;
    logic rdy, r;
    b = '0; s = sw_v;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 5) == 0) begin
        int k;
        k = $urandom_range(0, 3);
        b[k] = ~b[k];
      end
      if ($urandom_range(0, 15) == 0) s = W'($urandom);
      rdy = ($urandom_range(0, 3) == 0);
      r = ($urandom_range(0, 499) == 0);
      step(b, s, rdy, r);
      vectors++; if (state_o !== (3'b100 >> m_idx)) begin miscompares++; $display("FAIL rnd_state c=%0d got=%b exp=%b", c, state_o, 3'b100 >> m_idx); end
      vectors++; if (sw_o !== m_sw2) begin miscompares++; $display("FAIL rnd_sw c=%0d got=%h exp=%h", c, sw_o, m_sw2); end
      vectors++; if (cmd_valid_o !== m_valid || busy_o !== m_valid) begin
        miscompares++; $display("FAIL rnd_valid c=%0d got=%b/%b exp=%b", c, cmd_valid_o, busy_o, m_valid); end
      if (m_valid) begin
        vectors++; if (cmd_op_o !== m_op || cmd_data_o !== m_data) begin
          miscompares++; $display("FAIL rnd_cmd c=%0d got=%b/%h exp=%b/%h", c, cmd_op_o, cmd_data_o, m_op, m_data); end
      end
`ifdef PANEL_DROP_CNT_EN
      vectors++; if (drop_cnt_o !== 8'(m_drop)) begin miscompares++; $display("FAIL rnd_drop c=%0d got=%0d exp=%0d", c, drop_cnt_o, m_drop); end
`endif
    end
  endtask
  initial begin
    test_reset;
    test_cnt_toggle;
    test_mode;
    test_lru_wr;
    test_bounce;
    test_clr_drop;
    test_reset_pending;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/panel_input.md
Name: panel_input

Overview:
Front-panel input collector, the input-side counterpart of the display path. Synchronizes and debounces push-buttons, synchronizes switches, and keeps the one-hot panel mode that drives the display and status LEDs. Turns button presses into single command transactions toward the core over a valid/ready handshake.

Parameters:
DEBOUNCE_CYCLES, 100000, consecutive stable cycles required to accept a button level change (1 ms at 100 MHz); legal range 2 or more.
SW_W, 16, switch bus width.

Ports:
clk_i  in  1  system clock.
rst_i  in  1  reset; synchronous, active-high.
btn_i  in  4  raw buttons {btnr, btnl, btnu, btnc}; asynchronous, bouncing.
sw_i  in  SW_W  raw switches; asynchronous.
state_o  out  3  one-hot mode: CNT_EN=3'b100, LRU_WR=3'b010, LRU_RD=3'b001.
sw_o  out  SW_W  synchronized switches, for the display.
cmd_valid_o  out  1  command pending.
cmd_ready_i  in  1  core accepts the command.
cmd_op_o  out  2  00 CNT_TOGGLE, 01 LRU_WR, 10 LRU_RD, 11 CLR.
cmd_data_o  out  SW_W  command payload (switch snapshot).
busy_o  out  1  equals cmd_valid_o.

Behaviour:
- Reset values: state_o=CNT_EN, sw_o=0, cmd_valid_o=0, cmd_op_o=0, cmd_data_o=0, all synchronizer, debounce, and stable registers=0.
- Reset has priority over every other event and aborts a pending command; cmd_valid_o is 0 on the next cycle.
- Synchronization: btn_i and sw_i each pass through two flops. sw_o is the second flop.
- Debounce (per button):
  - Counter clears whenever the synchronized level equals the stable level.
  - Otherwise it increments.
  - When the counter reaches DEBOUNCE_CYCLES-1 with the level still different, the stable level takes the synchronized value and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES cycles never changes the stable level.
- Press: one-cycle pulse, registered, on a 0->1 transition of a stable level. Releases generate nothing.
- Latency: for a clean btn_i rise, cmd_valid_o or the state_o change occurs exactly DEBOUNCE_CYCLES+4 cycles later (2 sync, DEBOUNCE_CYCLES debounce, 1 press register, 1 issue).
- Command issue, in the cycle after a press pulse, only when cmd_valid_o=0:
  - btnu gives CLR, cmd_data_o=0.
  - btnc in CNT_EN gives CNT_TOGGLE, cmd_data_o=0.
  - btnc in LRU_WR gives LRU_WR, cmd_data_o=sw_o snapshot.
  - btnc in LRU_RD gives LRU_RD, cmd_data_o=sw_o snapshot (address in low bits).
  - btnu and btnc pressed in the same cycle: btnu wins, btnc is dropped.
- Handshake:
  - cmd_valid_o, cmd_op_o, and cmd_data_o stay constant until the cycle in which cmd_valid_o and cmd_ready_i are both 1; cmd_valid_o drops on the next cycle.
  - Switch changes while pending do not alter cmd_data_o.
  - Any btnc or btnu press while pending is dropped, not queued.
  - A new command can issue the cycle after acceptance.
- Mode FSM, states CNT_EN, LRU_WR, LRU_RD:
  - btnr steps CNT_EN->LRU_WR->LRU_RD->CNT_EN.
  - btnl steps in reverse.
  - btnl and btnr in the same cycle: no change.
  - Mode change is ignored while cmd_valid_o=1 or in a cycle that issues a command, so the command op reflects the mode registered at issue.
  - state_o is never anything other than one of the three one-hot codes.

Optional Feature:
PANEL_DROP_CNT_EN:
- Defined: adds output drop_cnt_o [7:0]. It counts btnc/btnu presses dropped while pending, plus the btnc lost in a simultaneous btnc/btnu press. It saturates at 255, clears on reset, and gains at most +1 per cycle.
- Undefined: the port and the counter are absent; behaviour is otherwise identical.

Decomposition:
- Shared package panel_pkg holds the mode one-hot localparams (COND_CNT_EN, COND_LRU_WR, COND_LRU_RD, shared with the display path), the op codes (OP_CNT_TOGGLE, OP_LRU_WR, OP_LRU_RD, OP_CLR), and the button index constants.
- One sub-module, btn_debounce: sync, counter, stable level, press pulse; instantiated 4 times with DEBOUNCE_CYCLES passed down.

Test Plan (DEBOUNCE_CYCLES=4):
- Reset, then btnc held high from cycle 0 with ready=0 -> cmd_valid_o=1 at cycle 8, op=00, data=0; stays high until ready=1, drops the next cycle.
- btnr pressed 3 times, with release held for 10 cycles each time -> state_o goes 100, 010, 001, 100; btnl once from 100 -> 001.
- Mode LRU_WR, sw_i=16'hA5C3, press btnc, change sw_i to 16'h0000 while ready=0 -> op=01, data=A5C3 held until accept.
- btnc bounce: 3-cycle high pulses separated by 1-cycle lows, then stays low -> no command, no mode change.
- btnu and btnc in the same cycle in LRU_RD -> single CLR command (op=11, data=0); with PANEL_DROP_CNT_EN, drop_cnt_o=1. A second btnc while pending -> ignored, drop_cnt_o=2.
- rst_i asserted for 1 cycle while cmd_valid_o=1 in mode LRU_RD -> next cycle cmd_valid_o=0, state_o=100, sw_o=0.
